// File: rtl/booth_pkg.sv
// Shared mode encodings and default width for the radix-2 Booth datapath.
// The A and Q mode codes are the {LA1,LA0} / {LQ1,LQ0} control pairs.
package booth_pkg;

    localparam int BOOTH_N = 8;

    localparam logic [1:0] A_HOLD  = 2'b00;
    localparam logic [1:0] A_LOAD  = 2'b01;
    localparam logic [1:0] A_SHIFT = 2'b10;
    localparam logic [1:0] A_CLEAR = 2'b11;

    localparam logic [1:0] Q_HOLD  = 2'b00;
    localparam logic [1:0] Q_LOAD  = 2'b01;
    localparam logic [1:0] Q_SHIFT = 2'b10;
    localparam logic [1:0] Q_CLEAR = 2'b11;

endpackage

// File: rtl/booth_addsub.sv
// Combinational W-bit adder/subtractor for the Booth accumulator: result = a + m or a - m.
// Latency: none (purely combinational). Backpressure: none.
module booth_addsub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] m,
    input  logic         sub,
    output logic [W-1:0] result
);

    assign result = sub ? (a - m) : (a + m);

endmodule

// File: rtl/booth_datapath.sv
// Booth multiplier datapath: M/A/Q/Qm1 registers, add/sub, coupled shift, product latch;
// 1-cycle register updates, product 1 cycle after done. No backpressure: controller-driven.
// Optional protocol checker enabled by defining BOOTH_DP_PROTOCOL_CHECK_EN.
module booth_datapath
    import booth_pkg::*;
#(
    parameter int N = BOOTH_N
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    input  logic             LM,
    input  logic             LA1,
    input  logic             LA0,
    input  logic             LQ1,
    input  logic             LQ0,
    input  logic             AS,
    input  logic             done,
    output logic             Q0,
    output logic             Qm1,
    output logic [2*N-1:0]   product,
    output logic             product_valid
`ifdef BOOTH_DP_PROTOCOL_CHECK_EN
    ,
    output logic             protocol_error
`endif
);

    localparam int W = N + 1;

    logic [1:0]     a_mode;
    logic [1:0]     q_mode;
    logic [W-1:0]   m_q, m_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   addsub_res;
    logic [N-1:0]   q_q, q_d;
    logic           qm1_q, qm1_d;
    logic [2*N-1:0] product_q, product_d;
    logic           product_valid_q, product_valid_d;

    assign a_mode = {LA1, LA0};
    assign q_mode = {LQ1, LQ0};

    booth_addsub #(
        .W(W)
    ) u_addsub (
        .a      (a_q),
        .m      (m_q),
        .sub    (AS),
        .result (addsub_res)
    );

    always_comb begin
        m_d             = m_q;
        a_d             = a_q;
        q_d             = q_q;
        qm1_d           = qm1_q;
        product_d       = product_q;
        product_valid_d = product_valid_q;

        if (LM) begin
            m_d = {multiplicand[N-1], multiplicand};
        end

        case (a_mode)
            A_LOAD:  a_d = addsub_res;
            A_SHIFT: a_d = {a_q[N], a_q[N:1]};
            A_CLEAR: a_d = '0;
            default: a_d = a_q;
        endcase

        // Latch from pre-edge A/Q; a same-cycle Q load below takes priority on valid.
        if (done && !product_valid_q) begin
            product_d       = {a_q[N-1:0], q_q};
            product_valid_d = 1'b1;
        end

        case (q_mode)
            Q_LOAD: begin
                q_d             = multiplier;
                qm1_d           = 1'b0;
                product_valid_d = 1'b0;
            end
            Q_SHIFT: begin
                q_d   = {a_q[0], q_q[N-1:1]};
                qm1_d = q_q[0];
            end
            Q_CLEAR: begin
                q_d   = '0;
                qm1_d = 1'b0;
            end
            default: begin
                q_d   = q_q;
                qm1_d = qm1_q;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m_q             <= '0;
            a_q             <= '0;
            q_q             <= '0;
            qm1_q           <= 1'b0;
            product_q       <= '0;
            product_valid_q <= 1'b0;
        end else begin
            m_q             <= m_d;
            a_q             <= a_d;
            q_q             <= q_d;
            qm1_q           <= qm1_d;
            product_q       <= product_d;
            product_valid_q <= product_valid_d;
        end
    end

    assign Q0            = q_q[0];
    assign Qm1           = qm1_q;
    assign product       = product_q;
    assign product_valid = product_valid_q;

`ifdef BOOTH_DP_PROTOCOL_CHECK_EN
    logic protocol_error_q, protocol_error_d;
    logic half_shift;
    logic bad_load;
    logic bad_done;

    always_comb begin
        half_shift       = (a_mode == A_SHIFT) != (q_mode == Q_SHIFT);
        bad_load         = (a_mode == A_LOAD) && (LM || (q_mode == Q_SHIFT));
        bad_done         = done && ((a_mode != A_HOLD) || (q_mode != Q_HOLD));
        protocol_error_d = protocol_error_q | half_shift | bad_load | bad_done;
    end

    // Sticky: only reset clears a recorded violation.
    always_ff @(posedge clock) begin
        if (reset) begin
            protocol_error_q <= 1'b0;
        end else begin
            protocol_error_q <= protocol_error_d;
        end
    end

    assign protocol_error = protocol_error_q;
`endif

endmodule
